// File: rtl/seven_seg_scan.sv
// ----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed scanner for a common-anode seven-segment display with
//   DIGITS digits. A prescaler divides clk down to one digit slot every
//   REFRESH_DIV cycles, and the active digit index steps through all digits.
//   The displayed value lives in a shadow register that is only updated at a
//   frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          1 = scanning, 0 = prescaler frozen and all anodes off
//   value       hex value, digit k = value[4k+3:4k]
//   load        single-cycle strobe that captures value/dp_in
//   dp_in       decimal point request per digit, active-high
//   blank_lz    1 = blank leading zero digits (digit 0 is never blanked)
//   nibble      hex code of the active digit, feeds the segment decoder
//   an          anode enables, active-low, at most one bit low
//   dp_n        decimal point of the active digit, active-low
//   frame_tick  one-cycle pulse after the last digit's slot ends
// ----------------------------------------------------------------------------
module seven_seg_scan #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     an,
   output logic                  dp_n,
   output logic                  frame_tick
);

   localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Prescaler and digit index
   logic [CNT_W-1:0]    cnt_reg;
   logic [IDX_W-1:0]    idx_reg;

   // Double buffer: pending capture and the shadow actually displayed
   logic [4*DIGITS-1:0] shadow_val_reg;
   logic [DIGITS-1:0]   shadow_dp_reg;
   logic [4*DIGITS-1:0] pend_val_reg;
   logic [DIGITS-1:0]   pend_dp_reg;
   logic                pend_reg;

   logic                tick;
   logic                frame_end;

   // Per-digit views of the shadow value
   logic [3:0]          digit_nib [DIGITS];
   logic [DIGITS-1:0]   upper_zero;   // digits k..DIGITS-1 are all zero
   logic [DIGITS-1:0]   blank;        // digit k is suppressed as a leading zero

   // Output register inputs
   logic [3:0]          nibble_next;
   logic [DIGITS-1:0]   an_next;
   logic                dp_n_next;
   logic                lit;

   // Gating with en keeps a frozen prescaler sitting on its last count from
   // repeatedly firing frame_end and consuming captures while disabled.
   assign tick      = en && (cnt_reg == CNT_LAST);
   assign frame_end = tick && (idx_reg == IDX_LAST);

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign digit_nib[gi] = shadow_val_reg[4*gi +: 4];

         // Zero-suffix chain built from the most significant digit downwards
         if (gi == DIGITS - 1) begin : g_top
            assign upper_zero[gi] = (digit_nib[gi] == 4'h0);
         end else begin : g_chain
            assign upper_zero[gi] = (digit_nib[gi] == 4'h0) && upper_zero[gi+1];
         end

         if (gi == 0) begin : g_units
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = blank_lz && upper_zero[gi];
         end
      end
   endgenerate

   // A blanked digit still presents its nibble, but anode and dp stay dark.
   always_comb begin
      lit         = en && !blank[idx_reg];
      nibble_next = digit_nib[idx_reg];
      an_next     = '1;
      dp_n_next   = 1'b1;
      if (lit) begin
         an_next   = ~(DIGITS'(1) << idx_reg);
         dp_n_next = ~shadow_dp_reg[idx_reg];
      end
   end

   // Prescaler and digit index; both hold while en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         idx_reg <= '0;
      end else if (tick) begin
         cnt_reg <= '0;
         idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else if (en) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // Capture path. A load at the frame boundary bypasses the pending buffer
   // so it is shown from the very next frame; any older pending load is
   // superseded by it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_val_reg <= '0;
         shadow_dp_reg  <= '0;
         pend_val_reg   <= '0;
         pend_dp_reg    <= '0;
         pend_reg       <= 1'b0;
      end else if (frame_end) begin
         if (load) begin
            shadow_val_reg <= value;
            shadow_dp_reg  <= dp_in;
         end else if (pend_reg) begin
            shadow_val_reg <= pend_val_reg;
            shadow_dp_reg  <= pend_dp_reg;
         end
         pend_reg <= 1'b0;
      end else if (load) begin
         pend_val_reg <= value;
         pend_dp_reg  <= dp_in;
         pend_reg     <= 1'b1;
      end
   end

   // Registered pin drivers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nibble     <= 4'h0;
         an         <= '1;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         nibble     <= nibble_next;
         an         <= an_next;
         dp_n       <= dp_n_next;
         frame_tick <= frame_end;
      end
   end

endmodule
